// File: rtl/audio_mix_pkg.sv
// Shared types and arithmetic helpers for the N-channel audio mixer.
// Helpers work on 64-bit values so one copy serves every datapath width.
package audio_mix_pkg;

    localparam int DEF_SAMPLE_BITS = 16;
    localparam int DEF_VOLUME_BITS = 8;

    typedef logic signed [DEF_SAMPLE_BITS-1:0] sample_t;
    typedef logic [DEF_VOLUME_BITS-1:0]        vol_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        MASTER,
        WRITE
    } mix_state_t;

    // All-ones gain is exact unity; otherwise floor((s * g) / 2^vb).
    function automatic logic signed [63:0] mix_gain(
        input logic signed [63:0] s,
        input logic [63:0]        g,
        input int unsigned        vb
    );
        logic signed [63:0] gs;
        gs = $signed(g);
        if (g == ((64'd1 << vb) - 64'd1))
            return s;
        return (s * gs) >>> vb;
    endfunction

    function automatic logic signed [63:0] sat_to(
        input logic signed [63:0] x,
        input int unsigned        bits
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = $signed((64'd1 << (bits - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/mix_gain_stage.sv
// Registered signed-by-unsigned scale with unity bypass.
// Shared by the per-channel and master volume paths.
module mix_gain_stage
    import audio_mix_pkg::*;
#(
    parameter int W  = 16,
    parameter int VB = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] s,
    input  logic [VB-1:0]       g,
    output logic signed [W-1:0] y
);

    always_ff @(posedge clk) begin
        if (rst)
            y <= '0;
        else
            y <= W'(mix_gain(64'(s), 64'(g), VB));
    end

endmodule

// File: rtl/audio_mixer_n.sv
// N-channel mixer: snapshot on tick, scale/accumulate one channel per
// clock, apply master volume, saturate and write into the player ring.
module audio_mixer_n
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
    parameter int VOLUME_BITS = DEF_VOLUME_BITS,
    parameter int BUF_LEN     = 256,
    parameter int LAG         = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     sample_tick,
    input  logic                                     refresh,
    input  logic [NUM_CH-1:0][SAMPLE_BITS-1:0]       ch_sample,
    input  logic [NUM_CH-1:0][VOLUME_BITS-1:0]       ch_vol,
    input  logic [NUM_CH-1:0]                        ch_en,
    input  logic [VOLUME_BITS-1:0]                   master_vol,
    input  logic [$clog2(BUF_LEN)-1:0]               play_index,
    input  logic                                     clr_stats,
    output logic                                     wr_en,
    output logic [$clog2(BUF_LEN)-1:0]               wr_addr,
    output logic signed [SAMPLE_BITS-1:0]            wr_data,
    output logic                                     busy,
    output logic                                     overrun,
    output logic [15:0]                              clip_count
);

    localparam int AW    = $clog2(BUF_LEN);
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = SAMPLE_BITS + $clog2(NUM_CH) + 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);
    localparam logic [CW:0]   NCH      = (CW + 1)'(NUM_CH);

    mix_state_t state, state_n;

    logic [NUM_CH-1:0][SAMPLE_BITS-1:0] snap_s;
    logic [NUM_CH-1:0][VOLUME_BITS-1:0] snap_v;
    logic [NUM_CH-1:0]                  snap_en;
    logic [VOLUME_BITS-1:0]             snap_m;
    logic [AW-1:0]                      addr_q;
    logic [CW-1:0]                      idx;
    logic [CW:0]                        nxt;
    logic signed [ACC_W-1:0]            acc;
    logic signed [ACC_W-1:0]            acc_sum;
    logic signed [SAMPLE_BITS-1:0]      ch_q;
    logic signed [ACC_W-1:0]            mst_q;
    logic [SAMPLE_BITS-1:0]             gs_in;
    logic [VOLUME_BITS-1:0]             gv_in;
    logic signed [SAMPLE_BITS-1:0]      sat_data;
    logic                               clip;
    logic                               go;
    logic                               ovr_ev;

    assign go      = sample_tick & refresh & (state == IDLE);
    assign ovr_ev  = sample_tick & refresh & (state != IDLE);
    assign nxt     = {1'b0, idx} + (CW + 1)'(1);
    assign acc_sum = acc + ACC_W'(ch_q);

    // The channel stage runs one channel ahead so the sum completes
    // in the last ACCUM cycle and feeds the master stage directly.
    always_comb begin
        gs_in = '0;
        gv_in = '0;
        if (state == IDLE) begin
            gs_in = ch_sample[0];
            gv_in = ch_en[0] ? ch_vol[0] : '0;
        end else if (nxt < NCH) begin
            gs_in = snap_s[nxt[CW-1:0]];
            gv_in = snap_en[nxt[CW-1:0]] ? snap_v[nxt[CW-1:0]] : '0;
        end
    end

    mix_gain_stage #(.W(SAMPLE_BITS), .VB(VOLUME_BITS)) u_ch_gain (
        .clk (clk),
        .rst (rst),
        .s   (gs_in),
        .g   (gv_in),
        .y   (ch_q)
    );

    mix_gain_stage #(.W(ACC_W), .VB(VOLUME_BITS)) u_mst_gain (
        .clk (clk),
        .rst (rst),
        .s   (acc_sum),
        .g   (snap_m),
        .y   (mst_q)
    );

    assign sat_data = SAMPLE_BITS'(sat_to(64'(mst_q), SAMPLE_BITS));
    assign clip     = sat_to(64'(mst_q), SAMPLE_BITS) != 64'(mst_q);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        busy    = (state != IDLE);
        unique case (state)
            IDLE:   if (go) state_n = ACCUM;
            ACCUM:  if (idx == LAST_IDX) state_n = MASTER;
            MASTER: state_n = WRITE;
            WRITE: begin
                wr_en   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_s  <= '0;
            snap_v  <= '0;
            snap_en <= '0;
            snap_m  <= '0;
            addr_q  <= '0;
            idx     <= '0;
            acc     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            unique case (state)
                IDLE: if (go) begin
                    snap_s  <= ch_sample;
                    snap_v  <= ch_vol;
                    snap_en <= ch_en;
                    snap_m  <= master_vol;
                    addr_q  <= play_index - AW'(LAG);
                    idx     <= '0;
                    acc     <= '0;
                end
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= idx + CW'(1);
                end
                MASTER: begin
                    wr_data <= sat_data;
                    wr_addr <= addr_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            overrun    <= 1'b0;
            clip_count <= '0;
        end else begin
            if (ovr_ev)
                overrun <= 1'b1;
            if (state == MASTER && clip && clip_count != 16'hFFFF)
                clip_count <= clip_count + 16'd1;
        end
    end

endmodule

// File: doc/audio_mixer_n.md
Name: audio_mixer_n

Overview:
- Parametrised N-channel audio combinator. Replaces the fixed two-source adder that feeds the player sample buffer.
- On each sample tick, snapshots every source sample and per-channel volume, then scales and accumulates them one channel per clock.
- Applies master volume, saturates to SAMPLE_BITS, and issues one write into the player ring buffer at a programmable lag behind the player read index.
- Sits between the sources (BRAM DMA, triangle, future oscillators) and the I2S player buffer; runs on the system clock.

Parameters:
- NUM_CH, 4, number of source channels (>=1)
- SAMPLE_BITS, 16, signed sample width
- VOLUME_BITS, 8, unsigned volume width (per-channel and master)
- BUF_LEN, 256, player ring buffer depth (power of two)
- LAG, 1, write position = play_index - LAG modulo BUF_LEN (1 <= LAG < BUF_LEN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle strobe per LR frame, already synchronised to clk
- refresh  in  1  mixer enable; when 0, ticks are ignored
- ch_sample  in  NUM_CH x SAMPLE_BITS  signed source samples
- ch_vol  in  NUM_CH x VOLUME_BITS  per-channel volume
- ch_en  in  NUM_CH  per-channel enable mask
- master_vol  in  VOLUME_BITS  master volume
- play_index  in  clog2(BUF_LEN)  current player read index
- clr_stats  in  1  clears clip_count and overrun
- wr_en  out  1  buffer write strobe
- wr_addr  out  clog2(BUF_LEN)  buffer write address
- wr_data  out  SAMPLE_BITS  signed mixed sample
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  sticky: a tick arrived while busy
- clip_count  out  16  saturating count of clipped output samples

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, overrun=0, clip_count=0; FSM goes to IDLE; accumulator cleared.
- Gain rule: scaled = (s * g) >>> VOLUME_BITS, arithmetic shift (floor). A gain of all-ones means unity: pass s unchanged. A gain of 0 gives 0.
- Accumulator width: SAMPLE_BITS + clog2(NUM_CH) + 1. No overflow is possible before saturation.
- FSM states: IDLE, ACCUM, MASTER, WRITE.
- IDLE: when sample_tick and refresh are both 1 in cycle T:
  - snapshot ch_sample, ch_vol, ch_en, master_vol, and the computed address (play_index - LAG) mod BUF_LEN;
  - clear the accumulator and the channel counter; go to ACCUM.
  - A tick with refresh=0 is ignored and does not set overrun.
- ACCUM: cycles T+1 .. T+NUM_CH, one channel per cycle in index order. A disabled channel contributes 0. After channel NUM_CH-1, go to MASTER.
- MASTER (cycle T+NUM_CH+1): apply the gain rule to the accumulator with the snapshotted master_vol, then saturate to [-2^(SAMPLE_BITS-1), 2^(SAMPLE_BITS-1)-1]. If saturation occurred, clip_count increments, holding at 0xFFFF.
- WRITE (cycle T+NUM_CH+2): wr_en=1 for exactly this cycle, with wr_addr/wr_data valid. Return to IDLE; busy drops on the next cycle.
- Latency: tick to wr_en is exactly NUM_CH+2 clocks. Minimum tick spacing is NUM_CH+3 clocks.
- sample_tick while busy: the tick is dropped, overrun is set to 1 and stays set, and the current mix completes normally.
- clr_stats coinciding with a clip or overrun event: the clear wins.
- Input changes after the snapshot have no effect on the mix in progress.
- rst during any state: abort immediately with no write; all outputs return to their reset values on the next edge.
- Address wrap: play_index < LAG wraps to BUF_LEN + play_index - LAG.

Decomposition:
- Package audio_mix_pkg holds: sample_t (signed SAMPLE_BITS), vol_t, the mixer FSM state enum, the gain function, and the saturate function.
- One sub-module, mix_gain_stage: a registered signed-by-unsigned scale with a unity bypass. It is reused for the per-channel multiply and the master multiply.

Test Plan:
- NUM_CH=4, ch0=1000, ch_vol0=0x80, ch_en=0001, master=0xFF, play_index=10, LAG=1 -> exactly one wr_en at T+6, wr_addr=9, wr_data=500, clip_count=0.
- ch0=ch1=30000, both vols=0xFF, ch_en=0011, master=0xFF -> wr_data=32767, clip_count=1. Repeat with -30000 each -> wr_data=-32768, clip_count=2.
- play_index=0, LAG=1, BUF_LEN=256 -> wr_addr=255. Separately, ch_en=0000 with nonzero samples -> wr_data=0.
- Second sample_tick at T+2 -> overrun=1, only one wr_en observed, wr_data correct for the first tick. Then clr_stats=1 -> overrun=0 and clip_count=0.
- rst asserted at T+2 during ACCUM -> no wr_en in the following 10 cycles, busy=0, outputs at reset values. A fresh tick afterwards mixes normally.
- refresh=0 with sample_tick pulses -> no writes, busy stays 0, overrun stays 0. Change ch_sample during ACCUM -> wr_data reflects the snapshot values.
